// File: rtl/elixirchip_es1_spu_ctrl_pkg.sv
// Shared types and helpers for SPU multiword sequencers.
// Combinational definitions only; no latency or flow control.
package elixirchip_es1_spu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } spu_ctrl_state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_sub.sv
// Narrow subtractor: s_data0 + ~s_data1 + s_carry, pipelined by LATENCY cycles.
// No backpressure; cke freezes the whole pipeline.
module elixirchip_es1_spu_op_sub #(
  parameter int    LATENCY         = 1,
  parameter int    DATA_BITS       = 8,
  parameter bit    USE_VALID       = 1'b1,
  parameter bit    IMMEDIATE_CARRY = 1'b0,
  parameter bit    USE_CLEAR       = 1'b0,
  parameter string DEVICE          = "RTL",
  parameter string SIMULATION      = "false",
  parameter string DEBUG           = "false"
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 cke,
  input  logic [DATA_BITS-1:0] s_data0,
  input  logic [DATA_BITS-1:0] s_data1,
  input  logic                 s_carry,
  input  logic                 s_clear,
  input  logic                 s_valid,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_carry,
  output logic                 m_msb_c,
  output logic                 m_valid
);

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 msb_c;
    logic [DATA_BITS-1:0] data;
  } stage_t;

  logic [DATA_BITS:0] sum;
  logic               clear;
  stage_t             st0;
  stage_t             st_out;

  assign clear = USE_CLEAR && s_clear;

  always_comb begin
    sum       = {1'b0, s_data0} + {1'b0, ~s_data1} + {{DATA_BITS{1'b0}}, s_carry};
    st0.valid = (USE_VALID ? s_valid : 1'b1) && !clear;
    st0.carry = sum[DATA_BITS];
    // carry into the msb recovered from the msb sum bit and its two addends
    st0.msb_c = s_data0[DATA_BITS-1] ^ ~s_data1[DATA_BITS-1] ^ sum[DATA_BITS-1];
    st0.data  = sum[DATA_BITS-1:0];
  end

  if (LATENCY == 0) begin : g_comb
    assign st_out = st0;
  end else begin : g_pipe
    stage_t pipe [LATENCY];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      end else if (cke) begin
        pipe[0] <= st0;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign st_out = pipe[LATENCY-1];
  end

  if (DEVICE == "RTL" && SIMULATION == "true" && DEBUG == "true") begin : g_dbg
    a_known_ctrl: assert property (@(posedge clk) disable iff (reset)
      cke |-> !$isunknown({s_valid, s_carry}));
  end

  assign m_data  = st_out.data;
  assign m_carry = IMMEDIATE_CARRY ? st0.carry : st_out.carry;
  assign m_msb_c = st_out.msb_c;
  assign m_valid = USE_VALID ? st_out.valid : 1'b1;

endmodule

// File: rtl/elixirchip_es1_spu_multiword_sub_ctrl.sv
// Wide subtract sequenced LSW-first over one narrow sub op; result after WORDS*(LATENCY+1)+1 cycles.
// s_ready only in IDLE; result held in OUT until m_ready; cke freezes everything.
module elixirchip_es1_spu_multiword_sub_ctrl
  import elixirchip_es1_spu_ctrl_pkg::*;
#(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter int    WORDS      = 4,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cke,
  input  logic [WORDS*DATA_BITS-1:0] s_data0,
  input  logic [WORDS*DATA_BITS-1:0] s_data1,
  input  logic                       s_carry,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [WORDS*DATA_BITS-1:0] m_data,
  output logic                       m_carry,
  output logic                       m_overflow,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int W  = WORDS * DATA_BITS;
  localparam int KW = cnt_width(WORDS);
  localparam int LW = cnt_width(LATENCY);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);
  localparam logic [LW-1:0] L_LAST = LW'((LATENCY > 0) ? LATENCY - 1 : 0);

  spu_ctrl_state_t      state, state_next;
  logic [W-1:0]         opa, opb, res, res_next;
  logic                 carry, ovf;
  logic [KW-1:0]        word_cnt;
  logic [LW-1:0]        wait_cnt;
  logic                 word_done, last_word, cap;
  logic                 op_valid, op_carry, op_msb_c, op_m_valid;
  logic [DATA_BITS-1:0] op_data;

  assign word_done = (state == ST_ISSUE && LATENCY == 0) ||
                     (state == ST_WAIT && wait_cnt == L_LAST);
  assign last_word = (word_cnt == K_LAST);
  assign cap       = cke && word_done && op_m_valid;
  // words arrive LSW first, so the result fills from the top and shifts down
  assign res_next  = W'({op_data, res} >> DATA_BITS);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else if (cke) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:           if (s_valid) state_next = ST_ISSUE;
      ST_ISSUE, ST_WAIT: begin
        if (!word_done)     state_next = ST_WAIT;
        else if (last_word) state_next = ST_OUT;
        else                state_next = ST_ISSUE;
      end
      ST_OUT:            if (m_ready) state_next = ST_IDLE;
      default:           state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready  = (state == ST_IDLE) && !reset;
    m_valid  = (state == ST_OUT);
    op_valid = (state == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else if (cke) begin
      if (state == ST_IDLE && s_valid) begin
        opa      <= s_data0;
        opb      <= s_data1;
        carry    <= s_carry;
        word_cnt <= '0;
      end
      if (state == ST_ISSUE)     wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (cap) begin
        opa      <= opa >> DATA_BITS;
        opb      <= opb >> DATA_BITS;
        res      <= res_next;
        carry    <= op_carry;
        ovf      <= op_carry ^ op_msb_c;
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end
    end
  end

  assign m_data     = res;
  assign m_carry    = carry;
  assign m_overflow = ovf;

  elixirchip_es1_spu_op_sub #(
    .LATENCY        (LATENCY),
    .DATA_BITS      (DATA_BITS),
    .USE_VALID      (1'b1),
    .IMMEDIATE_CARRY(1'b0),
    .USE_CLEAR      (1'b0),
    .DEVICE         (DEVICE),
    .SIMULATION     (SIMULATION),
    .DEBUG          (DEBUG)
  ) u_op (
    .reset  (reset),
    .clk    (clk),
    .cke    (cke),
    .s_data0(opa[DATA_BITS-1:0]),
    .s_data1(opb[DATA_BITS-1:0]),
    .s_carry(carry),
    .s_clear(1'b0),
    .s_valid(op_valid),
    .m_data (op_data),
    .m_carry(op_carry),
    .m_msb_c(op_msb_c),
    .m_valid(op_m_valid)
  );

endmodule

// File: tb/tb_elixirchip_es1_spu_multiword_sub_ctrl.sv
// Bench: three instances (LATENCY 1, 0, 3) driven in parallel and checked against a 32-bit
// arithmetic reference model.
module tb_elixirchip_es1_spu_multiword_sub_ctrl;

  localparam int DB = 8;
  localparam int NW = 4;
  localparam int W  = DB * NW;
  localparam int NL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset [NL], cke [NL], s_carry [NL], s_valid [NL], s_ready [NL];
  logic         m_carry [NL], m_overflow [NL], m_valid [NL], m_ready [NL];
  logic [W-1:0] s_data0 [NL], s_data1 [NL], m_data [NL];
  bit           done [NL];
  int           n_checks = 0;
  int           n_fail   = 0;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    elixirchip_es1_spu_multiword_sub_ctrl #(
      .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .DATA_BITS (DB),
      .WORDS     (NW),
      .DEVICE    ("RTL"),
      .SIMULATION("true"),
      .DEBUG     ("false")
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .cke       (cke[g]),
      .s_data0   (s_data0[g]),
      .s_data1   (s_data1[g]),
      .s_carry   (s_carry[g]),
      .s_valid   (s_valid[g]),
      .s_ready   (s_ready[g]),
      .m_data    (m_data[g]),
      .m_carry   (m_carry[g]),
      .m_overflow(m_overflow[g]),
      .m_valid   (m_valid[g]),
      .m_ready   (m_ready[g])
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  function automatic string tg(input int g, input string s);
    return $sformatf("L%0d %s", lat_of(g), s);
  endfunction

  // Returns {overflow, carry, result} of the full-width a + ~b + cin.
  function automatic logic [33:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
    logic [W:0] s;
    logic       ovf;
    s   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    return {ovf, s};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge whose following posedge accepts the operands.
  task automatic start_op(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input bit rnd);
    bit ok;
    ok = 1'b0;
    s_data0[g] = a;
    s_data1[g] = b;
    s_carry[g] = cin;
    s_valid[g] = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      cke[g] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_ready[g] && cke[g]) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check(tg(g, "accept timeout"), 0, 1);
  endtask

  // act counts enabled edges from the accepting edge up to m_valid.
  task automatic wait_result(input int g, input bit rnd, output logic [W-1:0] r,
                             output logic c, output logic o, output int act);
    logic ck_prev;
    bit   seen;
    seen    = 1'b0;
    act     = 0;
    ck_prev = cke[g];
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      s_valid[g] = 1'b0;
      if (ck_prev) act++;
      if (m_valid[g]) seen = 1'b1;
      else begin
        cke[g]  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ck_prev = cke[g];
      end
    end
    cke[g] = 1'b1;
    if (!seen) check(tg(g, "result timeout"), 0, 1);
    r = m_data[g];
    c = m_carry[g];
    o = m_overflow[g];
  endtask

  task automatic finish_op(input int g);
    m_ready[g] = 1'b1;
    cke[g]     = 1'b1;
    @(negedge clk);
    m_ready[g] = 1'b0;
    check(tg(g, "m_valid drop"), m_valid[g], 0);
  endtask

  task automatic run_op(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit rnd, input logic [33:0] exp,
                        input string name);
    logic [W-1:0] r;
    logic         c, o;
    int           act;
    start_op(g, a, b, cin, rnd);
    wait_result(g, rnd, r, c, o, act);
    check(tg(g, {name, " data"}), r, exp[31:0]);
    check(tg(g, {name, " carry"}), c, exp[32]);
    check(tg(g, {name, " ovf"}), o, exp[33]);
    check(tg(g, {name, " latency"}), act, 1 + NW * (lat_of(g) + 1));
    finish_op(g);
  endtask

  task automatic run_lat(input int g);
    logic [W-1:0] a, b, r;
    logic         cin, c, o;
    logic [33:0]  exp_a, exp_b;
    int           act;

    reset[g] = 1'b1; cke[g] = 1'b1; s_valid[g] = 1'b0; m_ready[g] = 1'b0;
    s_data0[g] = '0; s_data1[g] = '0; s_carry[g] = 1'b0;
    repeat (3) @(negedge clk);
    check(tg(g, "reset s_ready"), s_ready[g], 0);
    check(tg(g, "reset m_valid"), m_valid[g], 0);
    check(tg(g, "reset m_data"), m_data[g], 0);
    check(tg(g, "reset flags"), {m_carry[g], m_overflow[g]}, 0);
    reset[g] = 1'b0;
    @(negedge clk);
    check(tg(g, "s_ready after reset"), s_ready[g], 1);

    run_op(g, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 34'h0_FFFF_FFFF, "borrow-all");
    run_op(g, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 34'h3_7FFF_FFFF, "sign-ovf");
    run_op(g, 32'h0100_0000, 32'h0000_0001, 1'b1, 1'b0, 34'h1_00FF_FFFF, "ripple");
    run_op(g, 32'h0100_0000, 32'h0000_0001, 1'b0, 1'b0, 34'h1_00FF_FFFE, "ripple-cin0");

    // backpressure with the next operation already waiting on s_valid
    a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1));
    exp_a = ref_sub(a, b, cin);
    start_op(g, a, b, cin, 1'b0);
    wait_result(g, 1'b0, r, c, o, act);
    check(tg(g, "bp first data"), {o, c, r}, exp_a);
    a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1));
    exp_b = ref_sub(a, b, cin);
    s_data0[g] = a; s_data1[g] = b; s_carry[g] = cin; s_valid[g] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(tg(g, "bp hold ctrl"), {m_valid[g], s_ready[g]}, 2'b10);
      check(tg(g, "bp hold out"), {m_overflow[g], m_carry[g], m_data[g]}, exp_a);
    end
    m_ready[g] = 1'b1;
    @(negedge clk);
    m_ready[g] = 1'b0;
    check(tg(g, "bp release"), {m_valid[g], s_ready[g]}, 2'b01);
    wait_result(g, 1'b0, r, c, o, act);
    check(tg(g, "bp second data"), {o, c, r}, exp_b);
    check(tg(g, "bp second latency"), act, 1 + NW * (lat_of(g) + 1));
    finish_op(g);

    for (int i = 0; i < 12; i++) begin
      a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1));
      run_op(g, a, b, cin, 1'b0, ref_sub(a, b, cin), "rand");
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1));
      run_op(g, a, b, cin, 1'b1, ref_sub(a, b, cin), "rand-cke");
    end

    // reset while word 2 is in flight
    start_op(g, $urandom(), $urandom(), 1'b1, 1'b0);
    for (int i = 0; i < 1 + 2 * (lat_of(g) + 1); i++) begin
      @(negedge clk);
      s_valid[g] = 1'b0;
    end
    reset[g] = 1'b1;
    @(negedge clk);
    check(tg(g, "mid reset"), {m_valid[g], s_ready[g]}, 2'b00);
    reset[g] = 1'b0;
    @(negedge clk);
    check(tg(g, "mid reset release"), {m_valid[g], s_ready[g]}, 2'b01);
    run_op(g, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 34'h1_0123_4567, "post-reset");

    done[g] = 1'b1;
  endtask

  initial begin
    bit all_done;
    for (int g = 0; g < NL; g++) done[g] = 1'b0;
    fork
      run_lat(0);
      run_lat(1);
      run_lat(2);
    join_none
    all_done = 1'b0;
    for (int i = 0; i < 60000 && !all_done; i++) begin
      @(negedge clk);
      all_done = done[0] && done[1] && done[2];
    end
    if (!all_done) check("global timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
